e1_bram_pingpong_ctrl: RTL and testbench
========================================

// Module: e1_bram_pingpong_ctrl
// PURPOSE
//  Drives the write and read ports of the E1 dual-BRAM pair (bank0/bank1) as a ping-pong frame buffer.
//  Accepts a valid/ready input stream and writes frames of FRAME_LEN words alternately into bank0 and bank1.
//  Reads each completed bank back as a valid/ready output stream, in order, while the other bank fills.
//  Sits between the upstream word producer and the downstream consumer. BRAM read latency is 1 clk.
// PARAMETERS
//  BRAM_DATA_WIDTH  64                       word width
//  BRAM_DEPTH       64                       words per bank
//  BRAM_ADDR_WIDTH  clog2(BRAM_DEPTH)        bank address width
//  FRAME_LEN        BRAM_DEPTH               words per frame; legal range 2..BRAM_DEPTH
// PORTS
//  clk            in   1     clock
//  rst            in   1     synchronous reset, active-high
//  in_valid       in   1     input word valid
//  in_ready       out  1     input word accepted when in_valid && in_ready
//  in_data        in   DW    input word
//  out_valid      out  1     output word valid
//  out_ready      in   1     downstream accepts
//  out_data       out  DW    output word
//  out_last       out  1     marks the last word of a frame (address FRAME_LEN-1)
//  bank_full      out  2     per-bank "frame complete, unread" flag
//  bram0_wr_en    out  1     bank0 port-A enable
//  bram0_we       out  1     bank0 write enable (equals bram0_wr_en)
//  bram0_wr_addr  out  AW    bank0 write address
//  bram0_din      out  DW    bank0 write data
//  bram0_rd_en    out  1     bank0 port-B enable
//  bram0_rd_addr  out  AW    bank0 read address
//  bram0_dout     in   DW    bank0 read data, valid 1 clk after rd_en
//  bram1_*        --   --    same set and meaning as bram0_*, for bank1
// BEHAVIOUR
//  Reset:
//   - wr_bank=0, rd_bank=0, wr_ptr=0, rd_ptr=0, bank_full=2'b00.
//   - Output FIFO empty; out_valid=0, out_last=0.
//   - All bram*_en/we=0. In-flight reads are discarded.
//   - Reset mid-frame abandons the partial frame.
//  Write side:
//   - in_ready = !bank_full[wr_bank], driven combinationally.
//   - On accept: bram[wr_bank] wr_en=we=1, wr_addr=wr_ptr, din=in_data; wr_ptr++.
//   - Accept at wr_ptr==FRAME_LEN-1: wr_ptr<=0, bank_full[wr_bank]<=1, wr_bank toggles.
//  Read side:
//   - Issue a read when bank_full[rd_bank] && credit.
//   - credit = (fifo_cnt + inflight <= 1) || (out_valid && out_ready).
//   - On issue: bram[rd_bank] rd_en=1, rd_addr=rd_ptr; rd_ptr++.
//   - Next cycle, bram dout and a last tag (rd_ptr==FRAME_LEN-1 at issue) are pushed into a 2-entry output FIFO.
//   - Issue at rd_ptr==FRAME_LEN-1: rd_ptr<=0, bank_full[rd_bank]<=0, rd_bank toggles.
//     The writer's first write to that bank can land no earlier than the next edge, so there is no read/write collision.
//  Timing:
//   - With out_ready=1, out_valid rises 2 clks after the edge accepting a frame's last word.
//   - Sustained rate is 1 word/clk.
//   - Set and clear of bank_full in the same cycle always target different banks; both take effect.
//  Output:
//   - out_data and out_last hold stable while out_valid && !out_ready.
//   - No word is lost or duplicated.
//   - Frames are read in write order.
// CONFIGURATION
//  E1_PP_FRAME_CNT_EN defined:
//   - Adds output frame_cnt[15:0], reset to 0.
//   - Increments on each out_valid && out_ready && out_last, wrapping 0xFFFF->0.
//  Not defined:
//   - Port and counter are absent; all other behaviour is identical.
// TESTING
//  1 Reset, send 64 words 0..63, out_ready=1
//    -> out 0..63 in order, out_last only on 63, out_valid 2 clks after last accept, no gaps.
//  2 3 back-to-back frames (192 words), out_ready=1
//    -> in_ready never drops after reset, all 192 words in order.
//  3 out_ready=0, offer 129 words
//    -> bank_full=2'b11 after word 128, in_ready=0 at word 129.
//    Raise out_ready -> frame0 then frame1 out; in_ready=1 the clk after frame0's last read issue.
//  4 out_ready random 50%, 4 frames of random data
//    -> scoreboard match, out_data stable while stalled.
//  5 rst pulse after 10 words of frame0
//    -> out_valid=0, bank_full=0. Next frame writes bank0 from addr 0; the 10 stale words never appear.
//  6 With E1_PP_FRAME_CNT_EN, 3 frames drained
//    -> frame_cnt=3; after rst frame_cnt=0.

Source files
------------

// File: rtl/e1_bram_pingpong_ctrl.sv
// Ping-pong frame buffer controller for the E1 dual-BRAM pair: frames alternate banks on write, drain in order on read.
// Optional build macro E1_PP_FRAME_CNT_EN adds a frame_cnt output counting frames delivered downstream.
module e1_bram_pingpong_ctrl #(
  parameter int BRAM_DATA_WIDTH = 64,
  parameter int BRAM_DEPTH      = 64,
  parameter int BRAM_ADDR_WIDTH = $clog2(BRAM_DEPTH),
  parameter int FRAME_LEN       = BRAM_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [BRAM_DATA_WIDTH-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BRAM_DATA_WIDTH-1:0] out_data,
  output logic                       out_last,
  output logic [1:0]                 bank_full,
  output logic                       bram0_wr_en,
  output logic                       bram0_we,
  output logic [BRAM_ADDR_WIDTH-1:0] bram0_wr_addr,
  output logic [BRAM_DATA_WIDTH-1:0] bram0_din,
  output logic                       bram0_rd_en,
  output logic [BRAM_ADDR_WIDTH-1:0] bram0_rd_addr,
  input  logic [BRAM_DATA_WIDTH-1:0] bram0_dout,
  output logic                       bram1_wr_en,
  output logic                       bram1_we,
  output logic [BRAM_ADDR_WIDTH-1:0] bram1_wr_addr,
  output logic [BRAM_DATA_WIDTH-1:0] bram1_din,
  output logic                       bram1_rd_en,
  output logic [BRAM_ADDR_WIDTH-1:0] bram1_rd_addr,
  input  logic [BRAM_DATA_WIDTH-1:0] bram1_dout
`ifdef E1_PP_FRAME_CNT_EN
  ,
  output logic [15:0]                frame_cnt
`endif
);

  localparam int DW = BRAM_DATA_WIDTH;
  localparam int AW = BRAM_ADDR_WIDTH;
  localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_LEN - 1);

  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]    bank_full_q, bank_full_d;
  logic          inflight_q, inflight_d;
  logic          inflight_bank_q, inflight_bank_d;
  logic          inflight_last_q, inflight_last_d;
  logic [DW-1:0] fifo_data_q [2];
  logic [DW-1:0] fifo_data_d [2];
  logic [1:0]    fifo_last_q, fifo_last_d;
  logic          fifo_wr_idx_q, fifo_wr_idx_d;
  logic          fifo_rd_idx_q, fifo_rd_idx_d;
  logic [1:0]    fifo_cnt_q, fifo_cnt_d;

  logic          wr_fire;
  logic          rd_fire;
  logic          pop;
  logic          push;
  logic          credit;
  logic [DW-1:0] push_data;

  assign in_ready  = !bank_full_q[wr_bank_q];
  assign wr_fire   = in_valid && in_ready;
  assign out_valid = (fifo_cnt_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign push      = inflight_q;
  assign push_data = inflight_bank_q ? bram1_dout : bram0_dout;
  // Outstanding words (queued + in flight) never exceed the two FIFO slots.
  assign credit    = (({1'b0, fifo_cnt_q} + {2'b00, inflight_q}) <= 3'd1) || pop;
  assign rd_fire   = bank_full_q[rd_bank_q] && credit;

  assign out_data  = fifo_data_q[fifo_rd_idx_q];
  assign out_last  = out_valid && fifo_last_q[fifo_rd_idx_q];
  assign bank_full = bank_full_q;

  assign bram0_wr_en   = wr_fire && !wr_bank_q;
  assign bram0_we      = bram0_wr_en;
  assign bram0_wr_addr = wr_ptr_q;
  assign bram0_din     = in_data;
  assign bram0_rd_en   = rd_fire && !rd_bank_q;
  assign bram0_rd_addr = rd_ptr_q;

  assign bram1_wr_en   = wr_fire && wr_bank_q;
  assign bram1_we      = bram1_wr_en;
  assign bram1_wr_addr = wr_ptr_q;
  assign bram1_din     = in_data;
  assign bram1_rd_en   = rd_fire && rd_bank_q;
  assign bram1_rd_addr = rd_ptr_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    wr_bank_d       = wr_bank_q;
    rd_bank_d       = rd_bank_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    bank_full_d     = bank_full_q;
    inflight_d      = rd_fire;
    inflight_bank_d = rd_bank_q;
    inflight_last_d = (rd_ptr_q == LAST_ADDR);
    fifo_data_d     = fifo_data_q;
    fifo_last_d     = fifo_last_q;
    fifo_wr_idx_d   = fifo_wr_idx_q;
    fifo_rd_idx_d   = fifo_rd_idx_q;
    fifo_cnt_d      = fifo_cnt_q;

    if (wr_fire) begin
      if (wr_ptr_q == LAST_ADDR) begin
        wr_ptr_d               = '0;
        bank_full_d[wr_bank_q] = 1'b1;
        wr_bank_d              = !wr_bank_q;
      end else begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
    end

    // Reader only touches a full bank, writer only an empty one, so set and clear never collide.
    if (rd_fire) begin
      if (rd_ptr_q == LAST_ADDR) begin
        rd_ptr_d               = '0;
        bank_full_d[rd_bank_q] = 1'b0;
        rd_bank_d              = !rd_bank_q;
      end else begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
    end

    if (push) begin
      fifo_data_d[fifo_wr_idx_q] = push_data;
      fifo_last_d[fifo_wr_idx_q] = inflight_last_q;
      fifo_wr_idx_d              = !fifo_wr_idx_q;
    end
    if (pop) begin
      fifo_rd_idx_d = !fifo_rd_idx_q;
    end
    fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (rst) begin
      wr_bank_q       <= 1'b0;
      rd_bank_q       <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      bank_full_q     <= 2'b00;
      inflight_q      <= 1'b0;
      inflight_bank_q <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_last_q     <= 2'b00;
      fifo_wr_idx_q   <= 1'b0;
      fifo_rd_idx_q   <= 1'b0;
      fifo_cnt_q      <= 2'd0;
    end else begin
      wr_bank_q       <= wr_bank_d;
      rd_bank_q       <= rd_bank_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      bank_full_q     <= bank_full_d;
      inflight_q      <= inflight_d;
      inflight_bank_q <= inflight_bank_d;
      inflight_last_q <= inflight_last_d;
      fifo_last_q     <= fifo_last_d;
      fifo_wr_idx_q   <= fifo_wr_idx_d;
      fifo_rd_idx_q   <= fifo_rd_idx_d;
      fifo_cnt_q      <= fifo_cnt_d;
    end
  end

  // NOTE: FIFO payload is not reset; fifo_cnt_q alone decides whether a slot holds a valid word.
  always_ff @(posedge clk) begin
    fifo_data_q <= fifo_data_d;
  end

`ifdef E1_PP_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (pop && out_last) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) frame_cnt_q <= 16'd0;
    else     frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_e1_bram_pingpong_ctrl.sv
// Self-checking bench for e1_bram_pingpong_ctrl: BRAM models, queue-based frame model, directed + random stimulus.
module tb_e1_bram_pingpong_ctrl;
  localparam int DW = 64;
  localparam int DEPTH = 64;
  localparam int AW = 6;
  localparam int FL = 64;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [1:0]    bank_full;
  logic          bram0_wr_en, bram0_we, bram0_rd_en;
  logic [AW-1:0] bram0_wr_addr, bram0_rd_addr;
  logic [DW-1:0] bram0_din, bram0_dout;
  logic          bram1_wr_en, bram1_we, bram1_rd_en;
  logic [AW-1:0] bram1_wr_addr, bram1_rd_addr;
  logic [DW-1:0] bram1_din, bram1_dout;
`ifdef E1_PP_FRAME_CNT_EN
  logic [15:0]   frame_cnt;
`endif

  e1_bram_pingpong_ctrl #(
    .BRAM_DATA_WIDTH(DW),
    .BRAM_DEPTH     (DEPTH),
    .BRAM_ADDR_WIDTH(AW),
    .FRAME_LEN      (FL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .bank_full    (bank_full),
    .bram0_wr_en  (bram0_wr_en),
    .bram0_we     (bram0_we),
    .bram0_wr_addr(bram0_wr_addr),
    .bram0_din    (bram0_din),
    .bram0_rd_en  (bram0_rd_en),
    .bram0_rd_addr(bram0_rd_addr),
    .bram0_dout   (bram0_dout),
    .bram1_wr_en  (bram1_wr_en),
    .bram1_we     (bram1_we),
    .bram1_wr_addr(bram1_wr_addr),
    .bram1_din    (bram1_din),
    .bram1_rd_en  (bram1_rd_en),
    .bram1_rd_addr(bram1_rd_addr),
    .bram1_dout   (bram1_dout)
`ifdef E1_PP_FRAME_CNT_EN
    ,
    .frame_cnt    (frame_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two simple-dual-port BRAMs with one-cycle read latency.
  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];
  always @(posedge clk) begin
    if (bram0_we)    mem0[bram0_wr_addr] <= bram0_din;
    if (bram0_rd_en) bram0_dout <= mem0[bram0_rd_addr];
    if (bram1_we)    mem1[bram1_wr_addr] <= bram1_din;
    if (bram1_rd_en) bram1_dout <= mem1[bram1_rd_addr];
  end

  int checks = 0;
  int errors = 0;

  // Reference model: words collect into a partial frame; a complete frame joins the expected output queue.
  logic [DW-1:0] part_q [$];
  logic [DW-1:0] exp_q  [$];
  int  out_idx = 0;
  int  cyc = 0;
  int  last_acc_edge = 0;
  int  rise_edge = 0;
  int  frame_start_edge = 0;
  int  frame_span = 0;
  int  in_stalls = 0;
  int  frames_out = 0;
  bit  prev_ov = 0;
  bit  stalled_prev = 0;
  bit  acc_seen = 0;
  bit  saw_last_issue0 = 0;
  bit  rand_ready = 0;
  logic [DW-1:0] held_data;
  logic          held_last;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expd);
    checks++;
    assert (obs === expd) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expd);
    end
  endtask

  // One clock: observe at the falling edge, then advance past the rising edge.
  task automatic tick();
    acc_seen = 0;
    @(negedge clk);
    if (rst) begin
      part_q.delete();
      exp_q.delete();
      out_idx      = 0;
      prev_ov      = 0;
      stalled_prev = 0;
      frames_out   = 0;
    end else begin
      if (stalled_prev) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", out_data, held_data);
        check("hold_last", 64'(out_last), 64'(held_last));
      end
      if (out_valid && !prev_ov) rise_edge = cyc - 1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 64'(exp_q.size()), 64'd1);
        end else begin
          if (out_idx == 0) frame_start_edge = cyc;
          check("out_data", out_data, exp_q.pop_front());
          check("out_last", 64'(out_last), 64'(out_idx == FL - 1));
          if (out_idx == FL - 1) begin
            frame_span = cyc - frame_start_edge;
            frames_out++;
            out_idx = 0;
          end else begin
            out_idx++;
          end
        end
      end
      if (in_valid && !in_ready) in_stalls++;
      if (in_valid && in_ready) begin
        acc_seen = 1;
        part_q.push_back(in_data);
        if (part_q.size() == FL) begin
          exp_q = {exp_q, part_q};
          part_q.delete();
          last_acc_edge = cyc;
        end
      end
      if (bram0_rd_en && bram0_rd_addr == AW'(FL - 1)) saw_last_issue0 = 1;
      prev_ov      = out_valid;
      stalled_prev = out_valid && !out_ready;
      held_data    = out_data;
      held_last    = out_last;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rand_ready) out_ready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic send(input logic [DW-1:0] d);
    int budget = 2000;
    in_valid = 1'b1;
    in_data  = d;
    do begin
      tick();
      budget--;
    end while (!acc_seen && budget > 0);
    if (!acc_seen) check("send_accept", 64'(acc_seen), 64'd1);
  endtask

  task automatic drain();
    int budget = 5000;
    in_valid = 1'b0;
    while ((exp_q.size() != 0 || out_valid) && budget > 0) begin
      tick();
      budget--;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_bank_full", 64'(bank_full), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_bram_en", 64'({bram0_wr_en, bram0_rd_en, bram1_wr_en, bram1_rd_en}), 64'd0);

    // Single frame 0..63: latency from last accept and gap-free output.
    out_ready = 1'b1;
    for (int i = 0; i < FL; i++) send(64'(i));
    drain();
    check("first_out_latency", 64'(rise_edge - last_acc_edge), 64'd2);
    check("frame_no_gaps", 64'(frame_span), 64'(FL - 1));

    // Three back-to-back frames: writer never stalls.
    in_stalls = 0;
    for (int i = 0; i < 3 * FL; i++) send(64'(1000 + i));
    drain();
    check("b2b_in_stalls", 64'(in_stalls), 64'd0);
    check("b2b_frame_no_gaps", 64'(frame_span), 64'(FL - 1));

    // Downstream blocked: both banks fill, writer stalls until bank0 is fully issued.
    out_ready = 1'b0;
    for (int i = 0; i < 2 * FL; i++) send(64'(2000 + i));
    check("both_full", 64'(bank_full), 64'd3);
    in_valid = 1'b1;
    in_data  = 64'(2000 + 2 * FL);
    #1;
    check("blocked_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) tick();
    check("still_blocked", 64'(in_ready), 64'd0);
    saw_last_issue0 = 0;
    out_ready = 1'b1;
    for (int b = 0; b < 500 && !saw_last_issue0; b++) tick();
    check("saw_last_issue0", 64'(saw_last_issue0), 64'd1);
    check("in_ready_after_free", 64'(in_ready), 64'd1);
    for (int i = 0; i < FL; i++) send(64'(2000 + 2 * FL + i));
    drain();

    // Random backpressure and input gaps over four frames of random data.
    rand_ready = 1;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < FL; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          tick();
        end
        send({$urandom, $urandom});
      end
    end
    drain();
    rand_ready = 0;
    out_ready  = 1'b1;
`ifdef E1_PP_FRAME_CNT_EN
    check("frame_cnt_total", 64'(frame_cnt), 64'(frames_out));
`endif

    // Reset mid-frame: the ten partial words are dropped.
    for (int i = 0; i < 10; i++) send(64'(5000 + i));
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_bank_full", 64'(bank_full), 64'd0);
`ifdef E1_PP_FRAME_CNT_EN
    check("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
`endif
    in_valid = 1'b1;
    in_data  = 64'(3000);
    #1;
    check("post_rst_bank0_we", 64'(bram0_wr_en), 64'd1);
    check("post_rst_addr0", 64'(bram0_wr_addr), 64'd0);
    check("post_rst_bank1_idle", 64'(bram1_wr_en), 64'd0);
    for (int i = 0; i < FL; i++) send(64'(3000 + i));
    drain();

`ifdef E1_PP_FRAME_CNT_EN
    for (int i = 0; i < 2 * FL; i++) send(64'(4000 + i));
    drain();
    check("frame_cnt_three", 64'(frame_cnt), 64'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("frame_cnt_rst", 64'(frame_cnt), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
